// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine: one shift-add or restoring-subtract step per cycle.
// Holds the pipeline through stall while busy and presents a registered result with a done pulse.
module muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpRem    = 3'b110;

    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode in IDLE
    logic            sgn1, sgn2, s1_neg, s2_neg, is_div;
    logic            div_zero, div_ovf, accept;
    logic [XLEN-1:0] mag1, mag2, special_res;

    always_comb begin
        is_div   = op[2];
        sgn1     = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
        sgn2     = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
        s1_neg   = sgn1 & src1[XLEN-1];
        s2_neg   = sgn2 & src2[XLEN-1];
        mag1     = s1_neg ? (~src1 + 1'b1) : src1;
        mag2     = s2_neg ? (~src2 + 1'b1) : src2;
        div_zero = is_div && (src2 == '0);
        div_ovf  = ((op == OpDiv) || (op == OpRem)) && (src1 == MinNeg) && (src2 == AllOnes);
        accept   = start && !flush;
        if (div_zero) begin
            special_res = op[1] ? src1 : AllOnes;
        end else begin
            special_res = op[1] ? '0 : MinNeg;
        end
    end

    // Per-cycle arithmetic step and final sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift, div_diff;
    logic              div_borrow;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        div_shift  = {rem_q, acc_q[XLEN-1]};
        div_diff   = div_shift - {2'b00, opnd_q};
        div_borrow = div_diff[XLEN+1];
        prod_fix   = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix    = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix    = rem_neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = (div_zero || div_ovf) ? StDone : StCalc;
                    end
                end
                StCalc: begin
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        stall = rst && (((state_q == StIdle) && accept) ||
                        (state_q == StCalc) || (state_q == StFix));
        done   = (state_q == StDone);
        result = result_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        result_d  = result_q;
        if (!flush) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_d      = op;
                        neg_d     = s1_neg ^ s2_neg;
                        rem_neg_d = s1_neg;
                        cnt_d     = '0;
                        rem_d     = '0;
                        // Multiplier / dividend sits in the low half; the other operand is held
                        opnd_d    = is_div ? mag2 : mag1;
                        acc_d     = {{XLEN{1'b0}}, is_div ? mag1 : mag2};
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                        end
                    end
                end
                StCalc: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!op_q[2]) begin
                        acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                                         : {1'b0, acc_q[2*XLEN-1:1]};
                    end else begin
                        rem_d = div_borrow ? div_shift[XLEN:0] : div_diff[XLEN:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_borrow};
                    end
                end
                StFix: begin
                    unique case (op_q)
                        OpMul:                  result_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quo_fix;
                        default:                result_d = rem_fix;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results, latencies, flush and reset scenarios.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam logic [31:0] MinNeg = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MinNeg && b == 32'hFFFF_FFFF) return MinNeg;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MinNeg && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return o[2] && ((b == 0) || (!o[0] && a == MinNeg && b == 32'hFFFF_FFFF));
    endfunction

    // Timing model: an accepted op completes XLEN+1 edges later, special cases on the next edge
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;
    logic        exp_stall;

    always @(posedge clk) begin
        if (!rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left != 0) begin
            if (flush) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end
        end else if (start && !flush) begin
            if (is_special(op, src1, src2)) begin
                m_done <= 1'b1;
                m_res  <= ref_result(op, src1, src2);
            end else begin
                m_left <= XLEN + 1;
                m_pend <= ref_result(op, src1, src2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_stall = rst && ((m_left == 0 && !m_done && start && !flush) || m_left != 0);
            chk("cmp_stall", {31'h0, stall}, {31'h0, exp_stall});
            chk("cmp_done", {31'h0, done}, {31'h0, m_done});
            chk("cmp_result", result, m_res);
        end
    end

    // Counts cycles (including the current one) before done is seen; bounded
    task automatic wait_done(output int lat, output int stl);
        lat = 0;
        stl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
            lat++;
            if (stall) stl++;
        end
        chk("timeout", 32'd0, 32'd1);
    endtask

    // Called at posedge+1; leaves at posedge+1 after the DONE cycle with start low
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, stl;
        op    = o;
        src1  = a;
        src2  = b;
        start = 1'b1;
        wait_done(lat, stl);
        chk({name, "_res"}, result, exp);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_stall"}, stl, exp_lat);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        int lat, stl;
        rst   = 1'b0;
        start = 1'b1;
        flush = 1'b0;
        op    = 3'd0;
        src1  = 32'd3;
        src2  = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk_en = 1'b1;
        rst    = 1'b1;
        start  = 1'b0;

        chk("model_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model_div", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        @(posedge clk);
        #1;
        run_op("mul7", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
        run_op("mulh_min", 3'd1, MinNeg, MinNeg, 32'h4000_0000, 34);
        run_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu7", 3'd5, 32'd7, 32'd2, 32'd3, 34);
        run_op("remu7", 3'd7, 32'd7, 32'd2, 32'd1, 34);
        run_op("div_m100", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
        run_op("rem_m100", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
        run_op("divu_max", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", 3'd4, MinNeg, 32'hFFFF_FFFF, MinNeg, 1);
        run_op("rem_ovf", 3'd6, MinNeg, 32'hFFFF_FFFF, 32'h0, 1);

        // Flush during CALC cycle 10
        op    = 3'd5;
        src1  = 32'd100;
        src2  = 32'd7;
        start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_stall", {31'h0, stall}, 32'h0);
        chk("flush_done", {31'h0, done}, 32'h0);
        chk("flush_result", result, 32'h0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 34);

        // Reset during CALC with start held through it
        op    = 3'd0;
        src1  = 32'h0000_1234;
        src2  = 32'h0000_0010;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_result", result, 32'h0);
        chk("rst_mid_done", {31'h0, done}, 32'h0);
        rst = 1'b1;
        wait_done(lat, stl);
        chk("rst_restart_res", result, 32'h0001_2340);
        chk("rst_restart_lat", lat, 34);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
